// File: rtl/if_stage_if.sv
// Fetch-stage bundle: next-PC/flush control, instruction memory port and decode handoff.
// stall_count is present only when IF_STALL_CNT_EN is defined.
interface if_stage_if;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_count;

    modport master (
        input  next_pc, flush, imem_ack, imem_data, instr_ready,
        output pc, pc_plus4, imem_req, imem_addr, instr, instr_pc, instr_valid, stall_count
    );
    modport slave (
        output next_pc, flush, imem_ack, imem_data, instr_ready,
        input  pc, pc_plus4, imem_req, imem_addr, instr, instr_pc, instr_valid, stall_count
    );
`else
    modport master (
        input  next_pc, flush, imem_ack, imem_data, instr_ready,
        output pc, pc_plus4, imem_req, imem_addr, instr, instr_pc, instr_valid
    );
    modport slave (
        output next_pc, flush, imem_ack, imem_data, instr_ready,
        input  pc, pc_plus4, imem_req, imem_addr, instr, instr_pc, instr_valid
    );
`endif
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, one registered instruction for decode (IF_STALL_CNT_EN adds stall_count).
// Latency: instr_valid one cycle after imem_ack; next request the cycle after instr_valid&instr_ready.
// Backpressure: instr/instr_pc/pc held while instr_ready=0; flush overrides everything.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);
    typedef enum logic {S_REQ = 1'b0, S_OUT = 1'b1} state_t;

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        req_q;
    logic        vld_q;
    logic [31:0] next_pc_al;

    assign next_pc_al = {bus.next_pc[31:2], 2'b00};

    // req_q stays low through reset so an ack seen before the first edge is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc_q       <= RESET_PC_AL;
            instr_q    <= '0;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else if (bus.flush) begin
            state <= S_REQ;
            pc_q  <= next_pc_al;
            req_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    req_q <= 1'b1;
                    if (req_q && bus.imem_ack) begin
                        instr_q    <= bus.imem_data;
                        instr_pc_q <= pc_q;
                        pc_q       <= next_pc_al;
                        state      <= S_OUT;
                        req_q      <= 1'b0;
                        vld_q      <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.instr_ready) begin
                        state <= S_REQ;
                        req_q <= 1'b1;
                        vld_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_REQ;
                    req_q <= 1'b1;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where decode refused a valid instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (vld_q && !bus.instr_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_count = stall_q;
`endif

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + PC_STEP;
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = vld_q;
endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: driver predicts fetches into a queue, negedge monitor checks.
module tb_if_stage;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic        m_hold;
    logic [31:0] m_stall;
    logic [31:0] cur_pc;
    logic        cur_hold;
    logic [31:0] cur_stall;
    logic        chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // One clock of stimulus; the model advances to what the DUT should hold after the next edge
    task automatic cycle(input logic f, input logic [31:0] npc, input logic a,
                         input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        bus.flush       = f;
        bus.next_pc     = npc;
        bus.imem_ack    = a;
        bus.imem_data   = d;
        bus.instr_ready = r;
        cur_pc    = m_pc;
        cur_hold  = m_hold;
        cur_stall = m_stall;
        chk_en    = 1'b1;
        if (m_hold) begin
            if (!r && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (r) m_hold = 1'b0;
            if (f) begin
                if (!r && exp_q.size() > 0) exp_q.delete(0);
                m_hold = 1'b0;
                m_pc   = align(npc);
            end
        end else if (f) begin
            m_pc = align(npc);
        end else if (a) begin
            exp_q.push_back('{instr: d, pc: m_pc});
            m_pc   = align(npc);
            m_hold = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("pc", bus.pc, cur_pc);
            chk("pc_plus4", bus.pc_plus4, cur_pc + 32'd4);
            chk("imem_req", {31'd0, bus.imem_req}, {31'd0, !cur_hold});
            if (bus.imem_req) chk("imem_addr", bus.imem_addr, cur_pc);
            chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, cur_hold});
`ifdef IF_STALL_CNT_EN
            chk("stall_count", bus.stall_count, cur_stall);
`endif
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", {31'd0, bus.instr_valid}, 32'd0);
                end else begin
                    chk("instr", bus.instr, exp_q[0].instr);
                    chk("instr_pc", bus.instr_pc, exp_q[0].pc);
                    exp_q.delete(0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, bus.pc, 32'h0000_0000);
        chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
        chk({tag, "_instr"}, bus.instr, 32'd0);
        chk({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
`ifdef IF_STALL_CNT_EN
        chk({tag, "_stall"}, bus.stall_count, 32'd0);
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc    = 32'h0000_0000;
        m_hold  = 1'b0;
        m_stall = 32'd0;
    endtask

    initial begin
        chk_en          = 1'b0;
        rst_n           = 1'b0;
        bus.flush       = 1'b0;
        bus.next_pc     = 32'd0;
        bus.imem_ack    = 1'b1;
        bus.imem_data   = 32'hBAD0_BAD0;
        bus.instr_ready = 1'b0;
        model_reset();
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch with next_pc = pc + 4
        repeat (4) begin
            cycle(1'b0, m_pc + 32'd4, 1'b1, $urandom, 1'b1);
            cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b1);
        end

        // Held instruction under a 5-cycle decode stall
        cycle(1'b0, m_pc + 32'd4, 1'b1, 32'hDEAD_BEEF, 1'b0);
        repeat (5) cycle(1'b0, m_pc + 32'd4, 1'b1, 32'd0, 1'b0);
        cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b1);

        // Flush while holding, then flush coincident with ack
        cycle(1'b0, m_pc + 32'd4, 1'b1, $urandom, 1'b0);
        cycle(1'b1, 32'h0000_0100, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678, 1'b1);
        cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b1);

        // Flush together with acceptance still transfers the instruction
        cycle(1'b0, m_pc + 32'd4, 1'b1, $urandom, 1'b0);
        cycle(1'b1, 32'h0000_0200, 1'b0, 32'd0, 1'b1);

        // Wrap at the top of the address space and misaligned redirect targets
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, m_pc + 32'd4, 1'b1, $urandom, 1'b1);
        cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, m_pc + 32'd4, 1'b1, $urandom, 1'b1);
        cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'h0000_0013, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            logic f;
            logic [31:0] npc;
            f   = ($urandom_range(0, 9) == 0);
            npc = f ? $urandom : (m_pc + 32'd4 + 32'($urandom_range(0, 3)));
            cycle(f, npc, ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset in the middle of a held instruction
        cycle(1'b0, m_pc + 32'd4, 1'b1, $urandom, 1'b0);
        cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #3;
        chk_en       = 1'b0;
        rst_n        = 1'b0;
        bus.imem_ack = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            cycle(1'b0, m_pc + 32'd4, 1'b1, $urandom, 1'b1);
            cycle(1'b0, m_pc + 32'd4, 1'b0, 32'd0, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter PC_STEP, default 4, increment applied to form PC_PLUS4.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 NEXT_PC  input  32  next fetch address, driven by the downstream mux_2x32 Y output (mux A = PC_PLUS4, mux B = branch target).
REQ-006 FLUSH  input  1  redirect request; discards current fetch and reloads PC from NEXT_PC.
REQ-007 PC  output  32  current fetch address register.
REQ-008 PC_PLUS4  output  32  combinational PC + PC_STEP, modulo 2^32; feeds mux_2x32 input A.
REQ-009 IMEM_REQ  output  1  instruction memory request.
REQ-010 IMEM_ADDR  output  32  equals PC while IMEM_REQ=1.
REQ-011 IMEM_ACK  input  1  memory returns IMEM_DATA this cycle.
REQ-012 IMEM_DATA  input  32  fetched instruction word.
REQ-013 INSTR  output  32  registered instruction to decode.
REQ-014 INSTR_PC  output  32  address INSTR was fetched from.
REQ-015 INSTR_VALID  output  1  INSTR/INSTR_PC valid.
REQ-016 INSTR_READY  input  1  decode accepts INSTR this cycle.

Function
REQ-017 Two states: S_REQ (fetch outstanding) and S_OUT (instruction held for decode).
REQ-018 S_REQ: IMEM_REQ=1, INSTR_VALID=0; IMEM_ADDR stable at PC until IMEM_ACK.
REQ-019 S_REQ with IMEM_ACK=1, FLUSH=0: INSTR<=IMEM_DATA, INSTR_PC<=PC, PC<={NEXT_PC[31:2],2'b00}, go S_OUT; INSTR_VALID=1 on following cycle (1-cycle latency ACK->VALID).
REQ-020 S_OUT: IMEM_REQ=0, INSTR_VALID=1, INSTR and INSTR_PC held constant while INSTR_READY=0.
REQ-021 S_OUT with INSTR_READY=1: go S_REQ next cycle; one instruction transferred per VALID&READY cycle, never duplicated.
REQ-022 FLUSH has top priority in any state: PC<={NEXT_PC[31:2],2'b00}, INSTR_VALID<=0, state<=S_REQ; INSTR/INSTR_PC keep last values.
REQ-023 FLUSH and IMEM_ACK same cycle: IMEM_DATA discarded, no INSTR_VALID pulse, PC loads NEXT_PC.
REQ-024 FLUSH and INSTR_READY same cycle in S_OUT: instruction counts as accepted; PC loads NEXT_PC.
REQ-025 PC_PLUS4 wraps: PC=32'hFFFF_FFFC gives PC_PLUS4=32'h0000_0000; no flag.
REQ-026 NEXT_PC bits [1:0] ignored; PC[1:0] always 2'b00.
REQ-027 PC changes only on IMEM_ACK (S_REQ) or FLUSH; it never changes while INSTR_READY=0 holds S_OUT.

Reset
REQ-028 RST_N=0 asynchronously: PC=RESET_PC (low bits forced 00), state=S_REQ, INSTR=0, INSTR_PC=0, INSTR_VALID=0.
REQ-029 IMEM_REQ is 0 while RST_N=0 and rises on the first CLK edge after release.
REQ-030 Reset mid-fetch drops any outstanding request; an ACK during reset is ignored.

Configuration
REQ-031 Macro IF_STALL_CNT_EN defined: extra output STALL_COUNT[31:0] counts cycles with INSTR_VALID=1 and INSTR_READY=0, saturates at 32'hFFFF_FFFF, cleared only by reset (not FLUSH).
REQ-032 Macro IF_STALL_CNT_EN undefined: STALL_COUNT port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset release, RESET_PC=0, NEXT_PC tied to PC_PLUS4, IMEM_ACK one cycle after REQ, READY=1 -> INSTR_PC sequence 0,4,8,12; IMEM_ADDR=PC each request.
REQ-034 IMEM_DATA=32'hDEAD_BEEF acked, INSTR_READY=0 for 5 cycles -> INSTR held 32'hDEAD_BEEF, VALID=1, IMEM_REQ=0, PC stable; with IF_STALL_CNT_EN STALL_COUNT=5.
REQ-035 FLUSH with NEXT_PC=32'h0000_0100 during S_OUT -> VALID=0 next cycle, next IMEM_ADDR=32'h0000_0100.
REQ-036 FLUSH coincident with IMEM_ACK (data 32'h1234_5678), NEXT_PC=32'h40 -> no VALID pulse, next IMEM_ADDR=32'h40.
REQ-037 RESET_PC=32'hFFFF_FFFC, sequential fetch -> PC_PLUS4=0, second INSTR_PC=0; NEXT_PC=32'h0000_0013 on FLUSH -> PC=32'h0000_0010.
REQ-038 RST_N low mid-S_OUT -> INSTR_VALID=0, PC=RESET_PC immediately without clock edge.
